// File: rtl/dw02_mac.sv
// Combinational multiply-accumulate (A*B + C) mod 2^W with unsigned/two's-complement mode,
// built as a partial-product array with carry-save reduction, plus an enabled output register.
module dw02_mac #(
  parameter int A_width = 8,
  parameter int B_width = 8
) (
  input  logic                       MAC_ACC_CLK,
  input  logic                       acc_ff_rst,
  input  logic [A_width-1:0]         A,
  input  logic [B_width-1:0]         B,
  input  logic [A_width+B_width-1:0] C,
  input  logic                       TC,
  input  logic                       EN,
  output logic [A_width+B_width-1:0] MAC,
  output logic [A_width+B_width-1:0] MAC_Q
);

  localparam int W = A_width + B_width;

  logic [W-1:0]   a_ext_s;
  logic [W-1:0]   b_ext_s;
  logic [W-1:0]   pp_s;
  logic [W-1:0]   sum_s;
  logic [W-1:0]   carry_s;
  logic [2*W-1:0] csa_s;
  logic [W-1:0]   mac_s;
  logic [W-1:0]   mac_q_r;

  // 3:2 compressor over W-bit vectors; returns {carry, sum}, carry already weighted by 2.
  function automatic logic [2*W-1:0] csa(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [W-1:0] z);
    logic [W-1:0] s;
    logic [W-1:0] maj;
    s   = x ^ y ^ z;
    maj = (x & y) | (x & z) | (y & z);
    return {maj[W-2:0], 1'b0, s};
  endfunction

  // TC gates the sign-extension bits, so one array serves both signed and unsigned modes;
  // modulo 2^W the extended-operand product equals the true signed product.
  assign a_ext_s = {{B_width{TC & A[A_width-1]}}, A};
  assign b_ext_s = {{A_width{TC & B[B_width-1]}}, B};

  // Array reduction: fold C and each shifted partial product into a sum/carry pair.
  always_comb begin
    sum_s   = C;
    carry_s = {W{1'b0}};
    pp_s    = {W{1'b0}};
    csa_s   = {(2*W){1'b0}};
    for (int i = 0; i < W; i++) begin
      pp_s    = (a_ext_s & {W{b_ext_s[i]}}) << i;
      csa_s   = csa(sum_s, carry_s, pp_s);
      sum_s   = csa_s[W-1:0];
      carry_s = csa_s[2*W-1:W];
    end
  end

  // Single carry-propagate adder; carry out of bit W-1 is dropped.
  assign mac_s = sum_s + carry_s;
  assign MAC   = mac_s;

  // Output register: reset dominates the load enable.
  always_ff @(posedge MAC_ACC_CLK) begin
    if (acc_ff_rst) begin
      mac_q_r <= {W{1'b0}};
    end else if (EN) begin
      mac_q_r <= mac_s;
    end else begin
      mac_q_r <= mac_q_r;
    end
  end

  assign MAC_Q = mac_q_r;

endmodule

// File: tb/tb_dw02_mac.sv
// Self-checking bench for dw02_mac (10x10): directed cases, register control and a
// random regression against a behavioural model, through scoreboard queues.
module tb_dw02_mac;

  localparam int AW = 10;
  localparam int BW = 10;
  localparam int W  = AW + BW;

  logic          MAC_ACC_CLK;
  logic          acc_ff_rst;
  logic [AW-1:0] A;
  logic [BW-1:0] B;
  logic [W-1:0]  C;
  logic          TC;
  logic          EN;
  logic [W-1:0]  MAC;
  logic [W-1:0]  MAC_Q;

  logic [W-1:0] mac_sb[$];
  logic [W-1:0] macq_sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  dw02_mac #(.A_width(AW), .B_width(BW)) dut (
    .MAC_ACC_CLK(MAC_ACC_CLK),
    .acc_ff_rst (acc_ff_rst),
    .A          (A),
    .B          (B),
    .C          (C),
    .TC         (TC),
    .EN         (EN),
    .MAC        (MAC),
    .MAC_Q      (MAC_Q)
  );

  initial MAC_ACC_CLK = 1'b0;
  always #5 MAC_ACC_CLK = ~MAC_ACC_CLK;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                         input logic [W-1:0] c, input logic tc);
    longint av, bv, cv, r;
    av = tc ? longint'($signed(a)) : longint'(a);
    bv = tc ? longint'($signed(b)) : longint'(b);
    cv = tc ? longint'($signed(c)) : longint'(c);
    r  = av * bv + cv;
    return r[W-1:0];
  endfunction

  task automatic apply(input string tag, input logic [AW-1:0] a, input logic [BW-1:0] b,
                       input logic [W-1:0] c, input logic tc, input logic [W-1:0] exp);
    A = a; B = b; C = c; TC = tc;
    mac_sb.push_back(exp);
    #1;
    chk(tag, MAC, mac_sb.pop_front());
  endtask

  task automatic reg_step(input string tag, input logic en, input logic rst,
                          input logic [W-1:0] exp);
    @(negedge MAC_ACC_CLK);
    EN = en; acc_ff_rst = rst;
    macq_sb.push_back(exp);
    @(posedge MAC_ACC_CLK);
    #1;
    chk(tag, MAC_Q, macq_sb.pop_front());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [BW-1:0] rb;
    logic [W-1:0]  rc;
    logic          rt;
    acc_ff_rst = 1'b1; EN = 1'b0;
    A = 10'd0; B = 10'd0; C = 20'd0; TC = 1'b0;

    // Directed arithmetic cases
    apply("unsigned_basic", 10'd3, 10'd5, 20'd7, 1'b0, 20'h00016);
    apply("signed_neg1x2",  10'h3FF, 10'h002, 20'h0, 1'b1, 20'hFFFFE);
    apply("unsigned_3ffx2", 10'h3FF, 10'h002, 20'h0, 1'b0, 20'h007FE);
    apply("signed_extreme", 10'h200, 10'h200, 20'h0, 1'b1, 20'h40000);
    apply("signed_ext_cm1", 10'h200, 10'h200, 20'hFFFFF, 1'b1, 20'h3FFFF);
    apply("wraparound",     10'h3FF, 10'h3FF, 20'hFFFFF, 1'b0, 20'hFF800);
    apply("signed_1ffx200", 10'h1FF, 10'h200, 20'h0, 1'b1, 20'hC0200);
    apply("tc_switch",      10'h3FF, 10'h002, 20'h0, 1'b1, 20'hFFFFE);

    // Register control
    apply("mac_in_reset",   10'd3, 10'd5, 20'd7, 1'b0, 20'h00016);
    reg_step("q_reset",      1'b0, 1'b1, 20'h00000);
    reg_step("q_load",       1'b1, 1'b0, 20'h00016);
    apply("mac_changed",    10'd1, 10'd1, 20'd0, 1'b0, 20'h00001);
    reg_step("q_hold",       1'b0, 1'b0, 20'h00016);
    reg_step("q_rst_over_en",1'b1, 1'b1, 20'h00000);
    reg_step("q_rst_held",   1'b1, 1'b1, 20'h00000);
    reg_step("q_reload",     1'b1, 1'b0, 20'h00001);
    @(negedge MAC_ACC_CLK);
    EN = 1'b0;

    // Random regression, biased toward the signed extremes
    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 10'h200;
        1: ra = 10'h1FF;
        default: ra = AW'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: rb = 10'h200;
        1: rb = 10'h1FF;
        default: rb = BW'($urandom);
      endcase
      rc = W'($urandom);
      rt = 1'($urandom);
      apply("random", ra, rb, rc, rt, model(ra, rb, rc, rt));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
